// File: rtl/man_coder_pkg.sv
// Shared types, timing thresholds and bit-decode rule for the Manchester coder family.
// Thresholds are in clk cycles and scale with the half-bit length.
package man_coder_pkg;

    typedef enum logic [1:0] {
        THOMAS = 2'd0,
        IEEE   = 2'd1,
        DIFF   = 2'd2
    } man_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    function automatic int lim_lo(input int half_cyc);
        return 3 * half_cyc / 2;
    endfunction

    function automatic int lim_hi(input int half_cyc);
        return 5 * half_cyc / 2;
    endfunction

    function automatic int lim_gl(input int half_cyc);
        return half_cyc / 2;
    endfunction

    function automatic int cnt_width(input int half_cyc);
        return $clog2(5 * half_cyc / 2 + 1);
    endfunction

    // level is the line level just after the mid-bit edge
    function automatic logic decode_bit(input man_mode_e mode, input logic level, input logic bnd);
        case (mode)
            THOMAS:  return ~level;
            IEEE:    return level;
            default: return ~bnd;
        endcase
    endfunction

endpackage

// File: rtl/man_edge_sync.sv
// Two-flop synchronizer for the asynchronous line plus a one-cycle edge detector.
// Latency: line change visible on level/line_edge 2 clk after sampling; no backpressure.
module man_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic line_edge
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= line_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign level     = sync2;
    assign line_edge = sync2 ^ prev;

endmodule

// File: rtl/man_decoder_rx.sv
// Oversampling Manchester receiver: locks onto mid-bit transitions, strobes decoded bits, flags violations.
// Latency: 3 clk from sampled line transition to data_valid/code_err; no backpressure (strobe-only output).
module man_decoder_rx
    import man_coder_pkg::*;
#(
    parameter int HALF_CYC = 8,
    parameter int MODE     = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic data_out,
    output logic data_valid,
    output logic code_err,
    output logic locked
);

    localparam int              CW       = cnt_width(HALF_CYC);
    localparam logic [CW-1:0]   LO       = CW'(lim_lo(HALF_CYC));
    localparam logic [CW-1:0]   HI       = CW'(lim_hi(HALF_CYC));
    localparam logic [CW-1:0]   GL       = CW'(lim_gl(HALF_CYC));
    localparam man_mode_e       DEC_MODE = man_mode_e'(2'(MODE));

    logic          level;
    logic          line_edge;

    rx_state_e     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] elapsed;
    logic          bnd_seen, bnd_nxt;
    logic          dout_nxt, dval_nxt, err_nxt;

    man_edge_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .line_in   (line_in),
        .level     (level),
        .line_edge (line_edge)
    );

    // cnt is cleared on the accepting clock, so the current clock is one more than the register
    assign elapsed = (cnt == HI) ? HI : cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bnd_seen   <= 1'b0;
            data_out   <= 1'b0;
            data_valid <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bnd_seen   <= bnd_nxt;
            data_out   <= dout_nxt;
            data_valid <= dval_nxt;
            code_err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = elapsed;
        bnd_nxt   = bnd_seen;
        dout_nxt  = data_out;
        dval_nxt  = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (line_edge) begin
                    state_nxt = ACQ;
                    cnt_nxt   = '0;
                    bnd_nxt   = 1'b0;
                end
            end

            ACQ: begin
                if (line_edge) begin
                    cnt_nxt = '0;
                    if (elapsed >= LO) begin
                        state_nxt = LOCKED;
                        dval_nxt  = 1'b1;
                        dout_nxt  = decode_bit(DEC_MODE, level, 1'b0);
                        bnd_nxt   = 1'b0;
                    end
                end else if (elapsed == HI) begin
                    state_nxt = IDLE;
                end
            end

            LOCKED: begin
                if (line_edge) begin
                    if ((elapsed < GL) || ((elapsed < LO) && bnd_seen)) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                        bnd_nxt   = 1'b0;
                    end else if (elapsed < LO) begin
                        // boundary edge: keep timing from the previous mid-bit edge
                        bnd_nxt = 1'b1;
                    end else begin
                        dval_nxt = 1'b1;
                        dout_nxt = decode_bit(DEC_MODE, level, bnd_seen);
                        cnt_nxt  = '0;
                        bnd_nxt  = 1'b0;
                    end
                end else if (elapsed == HI) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                    bnd_nxt   = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_man_decoder_rx.sv
// Scoreboard bench for man_decoder_rx: one instance per line code, all fed the same line.
// Expected bits and strobe cycles are queued as mid-bit transitions are driven.
`timescale 1ns/1ps
module tb_man_decoder_rx;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       line_in = 1'b0;
    logic [2:0] dout, dval, cerr, lck;

    man_decoder_rx #(.HALF_CYC(H), .MODE(0)) u_thomas (
        .clk(clk), .reset(reset), .line_in(line_in),
        .data_out(dout[0]), .data_valid(dval[0]), .code_err(cerr[0]), .locked(lck[0]));

    man_decoder_rx #(.HALF_CYC(H), .MODE(1)) u_ieee (
        .clk(clk), .reset(reset), .line_in(line_in),
        .data_out(dout[1]), .data_valid(dval[1]), .code_err(cerr[1]), .locked(lck[1]));

    man_decoder_rx #(.HALF_CYC(H), .MODE(2)) u_diff (
        .clk(clk), .reset(reset), .line_in(line_in),
        .data_out(dout[2]), .data_valid(dval[2]), .code_err(cerr[2]), .locked(lck[2]));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic bit_v;
        int   cyc;
    } exp_t;

    exp_t       sb_q[$];
    logic [1:0] act = 2'd0;
    int         errs = 0;
    int         checks = 0;
    int         err_cnt = 0;
    int         err_cyc = 0;
    int         last_mid = 0;
    int         prev_mid = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mode 0 Thomas, 1 IEEE, 2 differential; j shifts the mid-bit transition
    task automatic send_bit(input int mode, input logic b, input int j, input logic en);
        logic a;
        case (mode)
            0:       a = b;
            1:       a = ~b;
            default: a = b ? line_in : ~line_in;
        endcase
        line_in = a;
        tick(H + j);
        line_in  = ~a;
        prev_mid = last_mid;
        last_mid = cyc;
        if (en) sb_q.push_back('{bit_v: b, cyc: cyc + 3});
        tick(H - j);
    endtask

    // jmode 1: payload mid edges jittered by +-3; jmode 2: last mid edge delayed by 5
    task automatic send_frame(input int mode, input logic [15:0] bits, input int n,
                              input int first, input int jmode);
        for (int i = 0; i < n; i++) begin
            int   j;
            logic en;
            j  = 0;
            en = (i >= first);
            if (jmode == 1 && i >= 8) j = (i % 2 == 0) ? 0 : ((i % 4 == 1) ? 3 : -3);
            if (jmode == 2 && i == n - 1) begin
                j  = 5;
                en = 1'b0;
            end
            send_bit(mode, bits[15 - i], j, en);
        end
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            tick(1);
            t++;
        end
        check(tag, sb_q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (dval[act]) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", dval[act], 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check("data_bit", dout[act], e.bit_v);
                    check("strobe_cycle", cyc, e.cyc);
                end
            end
            if (cerr[act]) begin
                err_cnt++;
                err_cyc = cyc;
                check("locked_with_err", lck[act], 1'b0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        line_in = 1'b0;
        tick(3);
        check("rst_data_out", dout, 0);
        check("rst_data_valid", dval, 0);
        check("rst_code_err", cerr, 0);
        check("rst_locked", lck, 0);
        reset = 1'b1;
        tick(40);

        // Thomas: preamble + 0xA5, then line held to force a timeout, then relock
        act = 2'd0; err_cnt = 0;
        send_frame(0, {8'hAA, 8'hA5}, 16, 1, 0);
        wait_drain("thomas_drain");
        check("thomas_locked", lck[0], 1'b1);
        check("thomas_no_err", err_cnt, 0);
        check("thomas_hold", dout[0], 1'b1);
        tick(30);
        check("miss_err_cnt", err_cnt, 1);
        check("miss_err_cycle", err_cyc, last_mid + 23);
        check("miss_unlocked", lck[0], 1'b0);
        err_cnt = 0;
        send_frame(0, {8'hAA, 8'hA5}, 16, 1, 0);
        wait_drain("relock_drain");
        check("relock_no_err", err_cnt, 0);
        tick(30);

        // IEEE 802.3
        act = 2'd1; err_cnt = 0;
        send_frame(1, {8'hAA, 8'hA5}, 16, 1, 0);
        wait_drain("ieee_drain");
        check("ieee_locked", lck[1], 1'b1);
        check("ieee_no_err", err_cnt, 0);
        tick(30);

        // differential: first strobe comes at the third preamble bit
        act = 2'd2; err_cnt = 0;
        send_frame(2, {8'hAA, 6'b110100, 2'b00}, 14, 2, 0);
        wait_drain("diff_drain");
        check("diff_no_err", err_cnt, 0);
        tick(30);

        // reset in the middle of the payload
        act = 2'd0; err_cnt = 0;
        send_frame(0, {8'hAA, 8'hA5}, 11, 1, 0);
        line_in = 1'b0;
        tick(4);
        check("pre_rst_drain", sb_q.size(), 0);
        check("pre_rst_locked", lck[0], 1'b1);
        check("pre_rst_dout", dout[0], 1'b1);
        reset = 1'b0;
        tick(1);
        check("mid_rst_dout", dout[0], 1'b0);
        check("mid_rst_dval", dval[0], 1'b0);
        check("mid_rst_err", cerr[0], 1'b0);
        check("mid_rst_locked", lck[0], 1'b0);
        tick(1);
        reset = 1'b1;
        tick(40);
        err_cnt = 0;
        send_frame(0, {8'hAA, 8'hA5}, 16, 1, 0);
        wait_drain("post_rst_drain");
        check("post_rst_no_err", err_cnt, 0);
        tick(30);

        // jitter within tolerance
        err_cnt = 0;
        send_frame(0, {8'hAA, 8'hA5}, 16, 1, 1);
        wait_drain("jitter_drain");
        check("jitter_no_err", err_cnt, 0);
        tick(30);

        // final mid edge arrives at interval 21
        err_cnt = 0;
        send_frame(0, {8'hAA, 8'hA5}, 16, 1, 2);
        wait_drain("late_drain");
        tick(30);
        check("late_err_cnt", err_cnt, 1);
        check("late_err_cycle", err_cyc, prev_mid + 23);
        check("late_unlocked", lck[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
